round_timer_ctrl: RTL and testbench
===================================

Name: round_timer_ctrl

Overview:
- Sequences the 1 ms tick generator to run a per-question countdown for the BCD math game.
- Enables and clears the tick generator and counts its tick pulses into whole seconds.
- Decrements a 2-digit BCD seconds value and flags expiry to the game FSM and the display path.
- Sits between the game FSM (start/stop/pause) and the tick generator plus seven-segment display.

Parameters:
ROUND_SECS, 8'h30, BCD reload value in seconds; must be valid BCD 00..99.
MS_PER_SEC, 1000, tick_in pulses per second; must be >= 2.
MS_W, 10, width of the internal ms counter; must satisfy 2^MS_W >= MS_PER_SEC.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level; sampled each cycle; loads ROUND_SECS and starts the countdown
stop  in  1  level; answer submitted, freezes the remaining time and returns to IDLE
pause  in  1  level; holds the countdown while high
tick_in  in  1  1-cycle pulse from the tick generator, once per ms
tick_en  out  1  enable to the tick generator
tick_rst_n  out  1  active-low clear to the tick generator
secs_bcd  out  8  remaining seconds as BCD {tens, ones}
running  out  1  high in RUN
expired  out  1  high in EXPIRED
expired_pulse  out  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- All outputs are registered. Reset gives state=IDLE, secs_bcd=ROUND_SECS, ms_cnt=0, tick_en=0, tick_rst_n=0, running=0, expired=0, expired_pulse=0.
- States are IDLE, RUN, PAUSE and EXPIRED.
- Command priority in every state: stop > start > pause.
- IDLE: tick_en=0 and tick_rst_n=0. On start: secs_bcd<=ROUND_SECS, ms_cnt<=0, go to RUN. If ROUND_SECS==8'h00, go directly to EXPIRED instead and pulse expired_pulse.
- RUN: tick_en=1, tick_rst_n=1, running=1.
  - On tick_in: if ms_cnt==MS_PER_SEC-1, then ms_cnt<=0 and secs_bcd decrements; otherwise ms_cnt<=ms_cnt+1.
  - BCD decrement: ones==0 gives ones=9 and tens-1; otherwise ones-1.
  - If the decremented value is 8'h00, go to EXPIRED. expired_pulse=1 on the cycle after the final tick.
- RUN commands:
  - pause=1 goes to PAUSE. ms_cnt is kept and no tick is counted that cycle.
  - stop=1 goes to IDLE. secs_bcd is frozen for scoring, ms_cnt<=0, and a same-cycle tick is ignored (the answer wins the race).
  - start=1 restarts: reload, ms_cnt<=0, stay in RUN.
- PAUSE: tick_en=0, tick_rst_n=1 so the generator keeps its partial count. Ticks are ignored.
  - pause=0 with no other command returns to RUN.
  - stop goes to IDLE.
  - start reloads and goes to RUN, even if pause is still high.
- EXPIRED: secs_bcd=8'h00, expired=1, tick_en=0, tick_rst_n=0.
  - start reloads and goes to RUN.
  - stop goes to IDLE; secs_bcd stays 00.
  - expired_pulse is high only on the first cycle in EXPIRED.
- Latency: tick_in to secs_bcd update is 1 cycle. Command to state/output change is 1 cycle.
- Reset mid-count fully restores the reset values, including reloading secs_bcd.
- secs_bcd never wraps below 00.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3) and the BCD digit constants 4'd0 and 4'd9.
- Sub-module bcd2_down: 8-bit BCD decrement, combinational, with a zero output for result==00. It is reusable by the score and countdown logic.
- The FSM, ms counter and output registers stay in round_timer_ctrl.

Test Plan:
- MS_PER_SEC=4, ROUND_SECS=8'h12: reset then start; 4 ticks -> secs_bcd=8'h11; 8 more ticks -> 8'h09 (ones borrow); tick_en=1 and running=1 throughout.
- ROUND_SECS=8'h02: start, 8 ticks -> secs_bcd=8'h00, expired_pulse high exactly 1 cycle, expired=1, tick_rst_n=0; a further tick leaves secs_bcd at 00.
- Pause mid-second: 2 ticks, pause=1, drive 5 ticks -> secs unchanged and tick_en=0; pause=0, 2 ticks -> secs decrements once (ms_cnt was preserved).
- ROUND_SECS=8'h01: stop and the final tick in the same cycle -> IDLE, secs_bcd=8'h01, expired stays 0.
- During RUN at secs 8'h07: start -> secs_bcd=ROUND_SECS and ms_cnt=0; then reset mid-run -> all outputs return to reset values on the next edge.
- ROUND_SECS=8'h00: start -> EXPIRED next cycle with expired_pulse=1.

Source files
------------

// File: rtl/round_timer_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : round_timer_ctrl_pkg
// Brief    : Shared state encoding and BCD digit constants for the round timer
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package round_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] c_bcd_zero = 4'd0;
  localparam logic [3:0] c_bcd_nine = 4'd9;

endpackage
`default_nettype wire

// File: rtl/round_timer_ctrl_bcd2_down.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : bcd2_down
// Brief    : Combinational 2-digit BCD decrement, saturating at 00, with a
//            flag that marks a result of 00
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module bcd2_down
  import round_timer_ctrl_pkg::*;
(
  input  logic [7:0] i_value,
  output logic [7:0] o_result,
  output logic       o_zero
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;

  assign w_tens = i_value[7:4];
  assign w_ones = i_value[3:0];

  // Borrow from the tens digit when ones is 0; hold at 00 so callers never wrap
  always_comb begin
    o_result = i_value;
    if (i_value == {c_bcd_zero, c_bcd_zero}) begin
      o_result = {c_bcd_zero, c_bcd_zero};
    end else if (w_ones == c_bcd_zero) begin
      o_result = {w_tens - 4'd1, c_bcd_nine};
    end else begin
      o_result = {w_tens, w_ones - 4'd1};
    end
  end

  assign o_zero = (o_result == {c_bcd_zero, c_bcd_zero});

endmodule
`default_nettype wire

// File: rtl/round_timer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : round_timer_ctrl
// Brief    : Per-question BCD seconds countdown driven by a 1 ms tick
//            generator; handles start/stop/pause and flags expiry
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module round_timer_ctrl
  import round_timer_ctrl_pkg::*;
#(
  parameter logic [7:0] ROUND_SECS = 8'h30,
  parameter int         MS_PER_SEC = 1000,
  parameter int         MS_W       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       tick_in,
  output logic       tick_en,
  output logic       tick_rst_n,
  output logic [7:0] secs_bcd,
  output logic       running,
  output logic       expired,
  output logic       expired_pulse
);

  localparam logic [MS_W-1:0] c_ms_last = MS_W'(MS_PER_SEC - 1);
  // A zero-length round skips RUN entirely
  localparam state_t c_load_state = (ROUND_SECS == 8'h00) ? S_EXPIRED : S_RUN;

  state_t            r_state;
  logic [MS_W-1:0]   r_ms;

  state_t            w_state_nxt;
  logic [7:0]        w_secs_nxt;
  logic [MS_W-1:0]   w_ms_nxt;
  logic [7:0]        w_dec;
  logic              w_dec_zero;

  bcd2_down u_dec (
    .i_value  (secs_bcd),
    .o_result (w_dec),
    .o_zero   (w_dec_zero)
  );

  // State, counters and outputs; outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ms          <= '0;
      secs_bcd      <= ROUND_SECS;
      tick_en       <= 1'b0;
      tick_rst_n    <= 1'b0;
      running       <= 1'b0;
      expired       <= 1'b0;
      expired_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ms          <= w_ms_nxt;
      secs_bcd      <= w_secs_nxt;
      tick_en       <= (w_state_nxt == S_RUN);
      tick_rst_n    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
      running       <= (w_state_nxt == S_RUN);
      expired       <= (w_state_nxt == S_EXPIRED);
      expired_pulse <= (w_state_nxt == S_EXPIRED) && (r_state != S_EXPIRED);
    end
  end

  // Next-state and datapath; command priority is stop > start > pause
  always_comb begin
    w_state_nxt = r_state;
    w_secs_nxt  = secs_bcd;
    w_ms_nxt    = r_ms;
    case (r_state)
      S_IDLE: begin
        if (stop) begin
          w_ms_nxt = '0;
        end else if (start) begin
          w_secs_nxt  = ROUND_SECS;
          w_ms_nxt    = '0;
          w_state_nxt = c_load_state;
        end
      end
      S_RUN: begin
        if (stop) begin
          // The submitted answer wins over a same-cycle tick
          w_ms_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_secs_nxt  = ROUND_SECS;
          w_ms_nxt    = '0;
          w_state_nxt = c_load_state;
        end else if (pause) begin
          w_state_nxt = S_PAUSE;
        end else if (tick_in) begin
          if (r_ms == c_ms_last) begin
            w_ms_nxt   = '0;
            w_secs_nxt = w_dec;
            if (w_dec_zero) begin
              w_state_nxt = S_EXPIRED;
            end
          end else begin
            w_ms_nxt = r_ms + MS_W'(1);
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          w_ms_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_secs_nxt  = ROUND_SECS;
          w_ms_nxt    = '0;
          w_state_nxt = c_load_state;
        end else if (!pause) begin
          w_state_nxt = S_RUN;
        end
      end
      S_EXPIRED: begin
        w_secs_nxt = 8'h00;
        if (stop) begin
          w_ms_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_secs_nxt  = ROUND_SECS;
          w_ms_nxt    = '0;
          w_state_nxt = c_load_state;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_round_timer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_round_timer_ctrl
// Brief    : Self-checking bench for round_timer_ctrl; four instances cover
//            different reload values with a fast 4-tick second
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_round_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] start = '0;
  logic [3:0] stop  = '0;
  logic [3:0] pause = '0;
  logic [3:0] tick  = '0;
  logic [3:0] tick_en;
  logic [3:0] tick_rst_n;
  logic [3:0] running;
  logic [3:0] expired;
  logic [3:0] expired_pulse;
  logic [7:0] secs [4];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] m_secs;
  int         m_ms;
  logic [7:0] got;
  logic [7:0] reset_secs [4];

  always #5 clk = ~clk;

  round_timer_ctrl #(.ROUND_SECS(8'h12), .MS_PER_SEC(4), .MS_W(2)) u_a (
    .clk(clk), .reset(reset), .start(start[0]), .stop(stop[0]), .pause(pause[0]),
    .tick_in(tick[0]), .tick_en(tick_en[0]), .tick_rst_n(tick_rst_n[0]),
    .secs_bcd(secs[0]), .running(running[0]), .expired(expired[0]),
    .expired_pulse(expired_pulse[0]));

  round_timer_ctrl #(.ROUND_SECS(8'h02), .MS_PER_SEC(4), .MS_W(2)) u_b (
    .clk(clk), .reset(reset), .start(start[1]), .stop(stop[1]), .pause(pause[1]),
    .tick_in(tick[1]), .tick_en(tick_en[1]), .tick_rst_n(tick_rst_n[1]),
    .secs_bcd(secs[1]), .running(running[1]), .expired(expired[1]),
    .expired_pulse(expired_pulse[1]));

  round_timer_ctrl #(.ROUND_SECS(8'h01), .MS_PER_SEC(4), .MS_W(2)) u_c (
    .clk(clk), .reset(reset), .start(start[2]), .stop(stop[2]), .pause(pause[2]),
    .tick_in(tick[2]), .tick_en(tick_en[2]), .tick_rst_n(tick_rst_n[2]),
    .secs_bcd(secs[2]), .running(running[2]), .expired(expired[2]),
    .expired_pulse(expired_pulse[2]));

  round_timer_ctrl #(.ROUND_SECS(8'h00), .MS_PER_SEC(4), .MS_W(2)) u_d (
    .clk(clk), .reset(reset), .start(start[3]), .stop(stop[3]), .pause(pause[3]),
    .tick_in(tick[3]), .tick_en(tick_en[3]), .tick_rst_n(tick_rst_n[3]),
    .secs_bcd(secs[3]), .running(running[3]), .expired(expired[3]),
    .expired_pulse(expired_pulse[3]));

  // Decimal-domain decrement, saturating at zero
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    int n;
    n = int'(v[7:4]) * 10 + int'(v[3:0]);
    n = (n > 0) ? n - 1 : 0;
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  // One clock with the given commands on instance d; inputs clear after the edge
  task automatic step(input int d, input logic st, input logic sp,
                      input logic ps, input logic tk);
    @(negedge clk);
    start[d] = st; stop[d] = sp; pause[d] = ps; tick[d] = tk;
    @(posedge clk);
    #1;
    start[d] = 1'b0; stop[d] = 1'b0; pause[d] = 1'b0; tick[d] = 1'b0;
  endtask

  // Running model tick: pushes the expected seconds value for that edge
  task automatic model_tick();
    m_ms = m_ms + 1;
    if (m_ms == 4) begin
      m_ms = 0;
      m_secs = bcd_dec(m_secs);
    end
    exp_q.push_back(m_secs);
  endtask

  task automatic test_reset();
    reset_secs = '{8'h12, 8'h02, 8'h01, 8'h00};
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (secs[i] !== reset_secs[i] || tick_en[i] !== 1'b0 || tick_rst_n[i] !== 1'b0 ||
          running[i] !== 1'b0 || expired[i] !== 1'b0 || expired_pulse[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: secs=%h en=%b rstn=%b run=%b exp=%b pulse=%b, required secs=%h and all flags 0",
                 i, secs[i], tick_en[i], tick_rst_n[i], running[i], expired[i], expired_pulse[i], reset_secs[i]);
      end
    end
  endtask

  task automatic test_countdown();
    step(0, 1, 0, 0, 0);
    m_secs = 8'h12; m_ms = 0;
    checks++;
    if (secs[0] !== 8'h12 || running[0] !== 1'b1 || tick_en[0] !== 1'b1 || tick_rst_n[0] !== 1'b1) begin
      errors++;
      $display("FAIL start: secs=%h run=%b en=%b rstn=%b, required 12/1/1/1",
               secs[0], running[0], tick_en[0], tick_rst_n[0]);
    end
    for (int t = 1; t <= 12; t++) begin
      model_tick();
      step(0, 0, 0, 0, 1);
      got = exp_q.pop_front();
      checks++;
      if (secs[0] !== got || running[0] !== 1'b1 || tick_en[0] !== 1'b1) begin
        errors++;
        $display("FAIL countdown tick %0d: secs=%h run=%b en=%b, required secs=%h run=1 en=1",
                 t, secs[0], running[0], tick_en[0], got);
      end
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (secs[0] !== 8'h09) begin
      errors++;
      $display("FAIL ones_borrow: secs=%h required 09", secs[0]);
    end
  endtask

  task automatic test_pause();
    repeat (2) begin
      model_tick();
      step(0, 0, 0, 0, 1);
      void'(exp_q.pop_front());
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (tick_en[0] !== 1'b0 || tick_rst_n[0] !== 1'b1 || running[0] !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter: en=%b rstn=%b run=%b, required 0/1/0",
               tick_en[0], tick_rst_n[0], running[0]);
    end
    repeat (5) step(0, 0, 0, 1, 1);
    checks++;
    if (secs[0] !== m_secs || tick_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL pause_hold: secs=%h en=%b, required secs=%h en=0", secs[0], tick_en[0], m_secs);
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (running[0] !== 1'b1 || tick_en[0] !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume: run=%b en=%b, required 1/1", running[0], tick_en[0]);
    end
    for (int t = 1; t <= 2; t++) begin
      model_tick();
      step(0, 0, 0, 0, 1);
      got = exp_q.pop_front();
      checks++;
      if (secs[0] !== got) begin
        errors++;
        $display("FAIL pause_ms_kept tick %0d: secs=%h required %h", t, secs[0], got);
      end
    end
  endtask

  task automatic test_restart_reset();
    repeat (4) begin
      model_tick();
      step(0, 0, 0, 0, 1);
      void'(exp_q.pop_front());
    end
    checks++;
    if (secs[0] !== 8'h07) begin
      errors++;
      $display("FAIL reach_07: secs=%h required 07", secs[0]);
    end
    repeat (2) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    m_secs = 8'h12; m_ms = 0;
    checks++;
    if (secs[0] !== 8'h12 || running[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart: secs=%h run=%b, required 12/1", secs[0], running[0]);
    end
    for (int t = 1; t <= 4; t++) begin
      model_tick();
      step(0, 0, 0, 0, 1);
      got = exp_q.pop_front();
      checks++;
      if (secs[0] !== got) begin
        errors++;
        $display("FAIL restart_ms_cleared tick %0d: secs=%h required %h", t, secs[0], got);
      end
    end
    repeat (2) step(0, 0, 0, 0, 1);
    @(negedge clk); reset = 1'b1; tick[0] = 1'b1;
    @(posedge clk); #1; reset = 1'b0; tick[0] = 1'b0;
    checks++;
    if (secs[0] !== 8'h12 || tick_en[0] !== 1'b0 || tick_rst_n[0] !== 1'b0 ||
        running[0] !== 1'b0 || expired[0] !== 1'b0 || expired_pulse[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: secs=%h en=%b rstn=%b run=%b exp=%b pulse=%b, required 12 and flags 0",
               secs[0], tick_en[0], tick_rst_n[0], running[0], expired[0], expired_pulse[0]);
    end
  endtask

  task automatic test_expiry();
    step(1, 1, 0, 0, 0);
    m_secs = 8'h02; m_ms = 0;
    for (int t = 1; t <= 8; t++) begin
      model_tick();
      step(1, 0, 0, 0, 1);
      got = exp_q.pop_front();
      checks++;
      if (secs[1] !== got || expired_pulse[1] !== (t == 8)) begin
        errors++;
        $display("FAIL expiry tick %0d: secs=%h pulse=%b, required secs=%h pulse=%b",
                 t, secs[1], expired_pulse[1], got, (t == 8));
      end
    end
    checks++;
    if (expired[1] !== 1'b1 || tick_rst_n[1] !== 1'b0 || tick_en[1] !== 1'b0 || running[1] !== 1'b0) begin
      errors++;
      $display("FAIL expired_flags: exp=%b rstn=%b en=%b run=%b, required 1/0/0/0",
               expired[1], tick_rst_n[1], tick_en[1], running[1]);
    end
    step(1, 0, 0, 0, 1);
    checks++;
    if (secs[1] !== 8'h00 || expired_pulse[1] !== 1'b0 || expired[1] !== 1'b1) begin
      errors++;
      $display("FAIL expired_hold: secs=%h pulse=%b exp=%b, required 00/0/1",
               secs[1], expired_pulse[1], expired[1]);
    end
    step(1, 0, 1, 0, 0);
    checks++;
    if (secs[1] !== 8'h00 || expired[1] !== 1'b0 || running[1] !== 1'b0) begin
      errors++;
      $display("FAIL expired_stop: secs=%h exp=%b run=%b, required 00/0/0", secs[1], expired[1], running[1]);
    end
    step(1, 1, 0, 0, 0);
    checks++;
    if (secs[1] !== 8'h02 || running[1] !== 1'b1) begin
      errors++;
      $display("FAIL idle_start_reload: secs=%h run=%b, required 02/1", secs[1], running[1]);
    end
  endtask

  task automatic test_stop_race();
    step(2, 1, 0, 0, 0);
    repeat (3) step(2, 0, 0, 0, 1);
    step(2, 0, 1, 0, 1);
    checks++;
    if (secs[2] !== 8'h01 || running[2] !== 1'b0 || expired[2] !== 1'b0 ||
        expired_pulse[2] !== 1'b0 || tick_rst_n[2] !== 1'b0) begin
      errors++;
      $display("FAIL stop_race: secs=%h run=%b exp=%b pulse=%b rstn=%b, required 01/0/0/0/0",
               secs[2], running[2], expired[2], expired_pulse[2], tick_rst_n[2]);
    end
    step(2, 0, 0, 0, 0);
    checks++;
    if (expired[2] !== 1'b0 || expired_pulse[2] !== 1'b0 || secs[2] !== 8'h01) begin
      errors++;
      $display("FAIL stop_race_after: secs=%h exp=%b pulse=%b, required 01/0/0",
               secs[2], expired[2], expired_pulse[2]);
    end
  endtask

  task automatic test_zero_round();
    step(3, 1, 0, 0, 0);
    checks++;
    if (expired[3] !== 1'b1 || expired_pulse[3] !== 1'b1 || running[3] !== 1'b0 || secs[3] !== 8'h00) begin
      errors++;
      $display("FAIL zero_round: exp=%b pulse=%b run=%b secs=%h, required 1/1/0/00",
               expired[3], expired_pulse[3], running[3], secs[3]);
    end
    step(3, 0, 0, 0, 0);
    checks++;
    if (expired_pulse[3] !== 1'b0 || expired[3] !== 1'b1) begin
      errors++;
      $display("FAIL zero_round_pulse_width: pulse=%b exp=%b, required 0/1", expired_pulse[3], expired[3]);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_restart_reset();
    test_expiry();
    test_stop_race();
    test_zero_round();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
